des_tdm_scheduler: RTL

- Upstream feeder and downstream collector for the Des_Top encryption core.
- Accepts plaintext/key blocks from NUM_CH independent channels and time-division multiplexes them onto the single core in fixed-length round-robin slots.
- Slot timing is independent of traffic, so core activity does not reveal which channel is active.
- Captures CIPHER_TEXT at the end of each slot and returns it on the owning channel's output.

---
 rtl/des_tdm_pkg.sv | 21 ++
 rtl/des_tdm_lfsr.sv | 24 ++
 rtl/des_tdm_scheduler.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/des_tdm_pkg.sv
// Shared types and constants for the DES time-division scheduler.
// The DES_DUMMY_FILL_EN build uses the LFSR constants below.
package des_tdm_pkg;

    localparam int DES_BLK_W = 64;

    // Fibonacci LFSR: taps 64,63,61,60 map to state bits 63,62,60,59
    localparam logic [DES_BLK_W-1:0] LFSR_SEED = 64'hACE1_0000_0000_0001;
    localparam logic [DES_BLK_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    typedef enum logic [1:0] {
        S_START,
        S_WAIT,
        S_CAPTURE
    } slot_state_t;

    function automatic int cnt_width(input int slot_len);
        return (slot_len > 1) ? $clog2(slot_len) : 1;
    endfunction

endpackage

// File: rtl/des_tdm_lfsr.sv
// 64-bit Fibonacci LFSR supplying dummy plaintext/key for empty TDM slots.
// Only instantiated when DES_DUMMY_FILL_EN is defined.
module des_tdm_lfsr
    import des_tdm_pkg::*;
(
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 step,
    output logic [DES_BLK_W-1:0] value
);

    logic [DES_BLK_W-1:0] lfsr_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            lfsr_reg <= LFSR_SEED;
        end else if (step) begin
            lfsr_reg <= {lfsr_reg[DES_BLK_W-2:0], ^(lfsr_reg & LFSR_TAPS)};
        end
    end

    assign value = lfsr_reg;

endmodule

// File: rtl/des_tdm_scheduler.sv
// Round-robin TDM feeder/collector for a single DES core with fixed-length slots.
// Define DES_DUMMY_FILL_EN to run LFSR dummy operations in empty slots.
module des_tdm_scheduler
    import des_tdm_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int DES_LATENCY = 17
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_CH-1:0]           IN_VALID,
    output logic [NUM_CH-1:0]           IN_READY,
    input  logic [DES_BLK_W*NUM_CH-1:0] IN_DATA,
    input  logic [DES_BLK_W*NUM_CH-1:0] IN_KEY,
    output logic [NUM_CH-1:0]           OUT_VALID,
    input  logic [NUM_CH-1:0]           OUT_READY,
    output logic [DES_BLK_W*NUM_CH-1:0] OUT_DATA,
    output logic                        DES_START,
    output logic                        DES_CS_BAR,
    output logic [DES_BLK_W-1:0]        DES_PT,
    output logic [DES_BLK_W-1:0]        DES_KEY,
    input  logic [DES_BLK_W-1:0]        DES_CT
);

    localparam int SLOT_LEN = DES_LATENCY + 2;
    localparam int CNT_W    = cnt_width(SLOT_LEN);
    localparam int SLOT_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0]  LAST_WAIT = CNT_W'(DES_LATENCY);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);

    slot_state_t          state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [SLOT_W-1:0]    slot_reg, slot_next;

    logic [NUM_CH-1:0]    slot_hit;
    logic [NUM_CH-1:0]    pending;
    logic [NUM_CH-1:0]    out_valid;
    logic [DES_BLK_W-1:0] pt_buf  [NUM_CH];
    logic [DES_BLK_W-1:0] key_buf [NUM_CH];

    logic                 live_reg;
    logic                 start_reg;
    logic                 cs_bar_reg;
    logic [DES_BLK_W-1:0] pt_reg, key_reg;

    logic                 issue;
    logic                 capture;
    logic [DES_BLK_W-1:0] sel_pt, sel_key;
    logic                 fill_en;
    logic [DES_BLK_W-1:0] fill_val;

    assign issue   = (state_reg == S_START) && |(slot_hit & pending & ~out_valid);
    assign capture = (state_reg == S_CAPTURE) && live_reg;

    // Per-channel input buffer and output holding register.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic                 pending_reg;
        logic                 out_valid_reg;
        logic [DES_BLK_W-1:0] pt_buf_reg, key_buf_reg, out_data_reg;
        logic                 accept;

        assign slot_hit[gi] = (slot_reg == SLOT_W'(gi));
        assign IN_READY[gi] = ~pending_reg & ~RST;
        assign accept       = IN_VALID[gi] & IN_READY[gi];

        always_ff @(posedge CLK) begin
            if (RST) begin
                pending_reg   <= 1'b0;
                out_valid_reg <= 1'b0;
                out_data_reg  <= '0;
            end else begin
                if (accept) begin
                    pending_reg <= 1'b1;
                end else if (issue && slot_hit[gi]) begin
                    pending_reg <= 1'b0;
                end
                // Issue is gated on out_valid being clear, so capture never meets a drain.
                if (capture && slot_hit[gi]) begin
                    out_valid_reg <= 1'b1;
                    out_data_reg  <= DES_CT;
                end else if (OUT_READY[gi]) begin
                    out_valid_reg <= 1'b0;
                end
            end
        end

        always_ff @(posedge CLK) begin
            if (accept) begin
                pt_buf_reg  <= IN_DATA[gi*DES_BLK_W +: DES_BLK_W];
                key_buf_reg <= IN_KEY[gi*DES_BLK_W +: DES_BLK_W];
            end
        end

        assign pending[gi]                        = pending_reg;
        assign out_valid[gi]                      = out_valid_reg;
        assign pt_buf[gi]                         = pt_buf_reg;
        assign key_buf[gi]                        = key_buf_reg;
        assign OUT_DATA[gi*DES_BLK_W +: DES_BLK_W] = out_data_reg;
    end

    always_comb begin
        sel_pt  = '0;
        sel_key = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (slot_hit[i]) begin
                sel_pt  = pt_buf[i];
                sel_key = key_buf[i];
            end
        end
    end

`ifdef DES_DUMMY_FILL_EN
    des_tdm_lfsr u_lfsr (
        .clk   (CLK),
        .srst  (RST),
        .step  ((state_reg == S_START) && !issue),
        .value (fill_val)
    );
    assign fill_en = 1'b1;
`else
    assign fill_val = '0;
    assign fill_en  = 1'b0;
`endif

    // Slot timing is traffic independent: every slot runs START, WAIT x DES_LATENCY, CAPTURE.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;
        slot_next  = slot_reg;
        case (state_reg)
            S_START: state_next = S_WAIT;
            S_WAIT: begin
                if (cnt_reg == LAST_WAIT) begin
                    state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_next = S_START;
                cnt_next   = '0;
                slot_next  = (slot_reg == LAST_SLOT) ? '0 : slot_reg + 1'b1;
            end
            default: begin
                state_next = S_START;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= S_START;
            cnt_reg    <= '0;
            slot_reg   <= '0;
            live_reg   <= 1'b0;
            start_reg  <= 1'b0;
            cs_bar_reg <= 1'b1;
            pt_reg     <= '0;
            key_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            slot_reg  <= slot_next;
            start_reg <= 1'b0;
            if (state_reg == S_START) begin
                live_reg <= issue;
                if (issue) begin
                    start_reg  <= 1'b1;
                    cs_bar_reg <= 1'b0;
                    pt_reg     <= sel_pt;
                    key_reg    <= sel_key;
                end else begin
                    start_reg  <= fill_en;
                    cs_bar_reg <= ~fill_en;
                    pt_reg     <= fill_val;
                    key_reg    <= fill_val;
                end
            end else if (state_reg == S_CAPTURE) begin
                cs_bar_reg <= 1'b1;
            end
        end
    end

    assign OUT_VALID  = out_valid;
    assign DES_START  = start_reg;
    assign DES_CS_BAR = cs_bar_reg;
    assign DES_PT     = pt_reg;
    assign DES_KEY    = key_reg;

endmodule
